// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes, FSM states
// and the small opcode decode helpers used by both control and datapath.
package muldiv_pkg;

    localparam int MD_WIDTH   = 32;
    localparam int ITER_CNT_W = $clog2(MD_WIDTH + 1);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return !op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multiply/divide unit: IDLE -> ITER (WIDTH steps) -> FIX -> IDLE,
// producing the datapath strobes plus the registered busy/done/div_by_zero outputs.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = ITER_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic dz_in,
    output logic load,
    output logic step,
    output logic fix,
    output logic dz_pend,
    output logic busy,
    output logic done,
    output logic div_by_zero
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    assign load = (state == IDLE) && start;
    assign step = (state == ITER);
    assign fix  = (state == FIX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            dz_pend     <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ITER;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        dz_pend <= dz_in;
                    end
                end
                ITER: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // done/div_by_zero land in the same cycle busy drops
                    state       <= IDLE;
                    cnt         <= '0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= dz_pend;
                    dz_pend     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Works on operand magnitudes; signs are restored in the FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    logic load, step, fix, dz_pend, dz_in;

    logic [WIDTH-1:0] acc, q, m;
    logic             is_div_q, neg_lo_q, neg_hi_q;

    logic             signed_op, sign_a, sign_b;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] product_fixed;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                             input logic is_signed);
        logic [WIDTH-1:0] u;
        u = v;
        return (is_signed && v[WIDTH-1]) ? (~u + 1'b1) : u;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    assign signed_op = op_is_signed(op);
    assign sign_a    = signed_op & src_a[WIDTH-1];
    assign sign_b    = signed_op & src_b[WIDTH-1];
    assign dz_in     = op_is_div(op) && (src_b == '0);

    // shift-add multiply: {acc,q} shifts right, multiplier bits consumed from q[0]
    assign mul_sum   = {1'b0, acc} + {1'b0, (q[0] ? m : '0)};
    // restoring divide: {acc,q} shifts left, quotient bits enter at q[0]
    assign div_shift = {acc, q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m};

    assign product_fixed = neg_2w({acc, q}, neg_lo_q);

    muldiv_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W ($clog2(WIDTH + 1))
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dz_in       (dz_in),
        .load        (load),
        .step        (step),
        .fix         (fix),
        .dz_pend     (dz_pend),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            q        <= '0;
            m        <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            if (load) begin
                acc      <= '0;
                q        <= op_is_div(op) ? mag(src_a, signed_op) : mag(src_b, signed_op);
                m        <= op_is_div(op) ? mag(src_b, signed_op) : mag(src_a, signed_op);
                is_div_q <= op_is_div(op);
                neg_lo_q <= sign_a ^ sign_b;
                neg_hi_q <= sign_a;
            end else if (step) begin
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc <= div_diff[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= div_shift[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc <= mul_sum[WIDTH:1];
                    q   <= {mul_sum[0], q[WIDTH-1:1]};
                end
            end

            if (fix) begin
                if (is_div_q) begin
                    // a zero divisor leaves |a| as remainder; the sign of a restores src_a
                    hi <= neg_w(acc, neg_hi_q);
                    lo <= dz_pend ? '1 : neg_w(q, neg_lo_q);
                end else begin
                    hi <= product_fixed[2*WIDTH-1:WIDTH];
                    lo <= product_fixed[WIDTH-1:0];
                end
            end else if (!busy) begin
                if (hi_we) hi <= wd;
                if (lo_we) lo <= wd;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a driver issues operations and queues the
// arithmetic results; a monitor pops and compares on every done pulse.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src_a = '0, src_b = '0, wd = '0;
    logic         hi_we = 1'b0, lo_we = 1'b0;
    logic [W-1:0] hi, lo;
    logic         busy, done, div_by_zero;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic [31:0] cyc;
    } exp_t;

    exp_t        scb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] cyc = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    logic        prev_done = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wd          (wd),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the operands.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        rdz = 1'b0;
        rh  = '0;
        rl  = '0;
        if (o == OP_MULT) begin
            p = 64'(sa * sb);
            rh = p[63:32]; rl = p[31:0];
        end else if (o == OP_MULTU) begin
            p = ua * ub;
            rh = p[63:32]; rl = p[31:0];
        end else if (b == 32'd0) begin
            rh = a; rl = 32'hFFFF_FFFF; rdz = 1'b1;
        end else if (o == OP_DIV) begin
            p = 64'(sa / sb); rl = p[31:0];
            p = 64'(sa % sb); rh = p[31:0];
        end else begin
            p = ua / ub; rl = p[31:0];
            p = ua % ub; rh = p[31:0];
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (done) begin
                if (scb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    mon_e = scb.pop_front();
                    check("hi", 64'(hi), 64'(mon_e.hi));
                    check("lo", 64'(lo), 64'(mon_e.lo));
                    check("div_by_zero", 64'(div_by_zero), 64'(mon_e.dz));
                    check("done_latency", 64'(cyc), 64'(mon_e.cyc));
                    check("busy_at_done", 64'(busy), 64'd0);
                end
            end else if (div_by_zero) begin
                check("dbz_without_done", 64'd1, 64'd0);
            end
            if (done && prev_done) check("done_width", 64'd2, 64'd1);
        end
        prev_done <= done;
    end

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic        ed;
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        model(o, a, b, eh, el, ed);
        scb.push_back('{hi: eh, lo: el, dz: ed, cyc: cyc + 32'd34});
        m_hi = eh; m_lo = el;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("busy_timeout", 64'(n), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] hb, lb;
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst = 1'b1;

        // directed vectors
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
        check("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max_lo", 64'(lo), 64'h0000_0001);
        start_op(OP_MULT, 32'hFFFF_FFFD, 32'd7); wait_idle();
        check("mult_neg_lo", 64'(lo), 64'hFFFF_FFEB);
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2); wait_idle();
        check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        start_op(OP_DIVU, 32'd100, 32'd0); wait_idle();
        start_op(OP_DIV, 32'd100, 32'd0); wait_idle();
        start_op(OP_DIV, 32'hFFFF_FF9C, 32'd0); wait_idle();
        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        check("div_ovf_lo", 64'(lo), 64'h8000_0000);

        // start and MTHI/MTLO during ITER are ignored
        hb = m_hi; lb = m_lo;
        start_op(OP_MULT, 32'h0001_2345, 32'hFFFF_0003);
        @(negedge clk);
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wd = 32'h1234; op = OP_DIVU;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        @(negedge clk);
        check("iter_write_hi", 64'(hi), 64'(hb));
        check("iter_write_lo", 64'(lo), 64'(lb));
        wait_idle();
        repeat (40) @(negedge clk);

        // asynchronous reset in the middle of a divide
        start_op(OP_DIVU, 32'hDEAD_BEEF, 32'd7);
        repeat (9) @(posedge clk);
        #1 rst = 1'b0;
        scb.delete();
        m_hi = 0; m_lo = 0;
        #1;
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(negedge clk); rst = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        start_op(OP_DIVU, 32'hDEAD_BEEF, 32'd7); wait_idle();

        // MTLO / MTHI while idle
        @(negedge clk); lo_we = 1'b1; wd = 32'hCAFE_F00D;
        @(negedge clk); lo_we = 1'b0;
        check("mtlo_lo", 64'(lo), 64'hCAFE_F00D);
        check("mtlo_hi", 64'(hi), 64'(m_hi));
        check("mtlo_busy", 64'(busy), 64'd0);
        m_lo = 32'hCAFE_F00D;
        @(negedge clk); hi_we = 1'b1; wd = 32'h0BAD_CAFE;
        @(negedge clk); hi_we = 1'b0;
        check("mthi_hi", 64'(hi), 64'h0BAD_CAFE);
        check("mthi_lo", 64'(lo), 64'(m_lo));

        // MTHI together with start: the result wins
        @(negedge clk); hi_we = 1'b1; wd = 32'h5555_AAAA;
        start_op(OP_MULTU, 32'h0000_1000, 32'h0010_0000);
        hi_we = 1'b0;
        wait_idle();

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            start_op(2'($urandom_range(0, 3)), pick(), pick());
            wait_idle();
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(scb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
